// File: rtl/ads131_spi_responder_pkg.sv
// ADS131A0x link constants shared by the responder and SPI_Master.
// Command codes, status words and FSM state encoding.
package ads131_spi_responder_pkg;

  localparam int WORD_BITS = 24;

  localparam logic [15:0] CMD_NULL    = 16'h0000;
  localparam logic [15:0] CMD_RESET   = 16'h0011;
  localparam logic [15:0] CMD_STANDBY = 16'h0022;
  localparam logic [15:0] CMD_WAKEUP  = 16'h0033;
  localparam logic [15:0] CMD_LOCK    = 16'h0555;
  localparam logic [15:0] CMD_UNLOCK  = 16'h0655;

  localparam logic [15:0] STATUS_READY = 16'hFF04;
  localparam logic [15:0] STATUS_NULL  = 16'h2200;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_POR    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  function automatic logic [15:0] status_for(input logic [15:0] cmd);
    logic [15:0] s;
    s = 16'h0000;
    unique case (1'b1)
      cmd == CMD_NULL:    s = STATUS_NULL;
      cmd == CMD_STANDBY: s = cmd;
      cmd == CMD_WAKEUP:  s = cmd;
      cmd == CMD_LOCK:    s = cmd;
      cmd == CMD_UNLOCK:  s = cmd;
      default:            s = 16'h0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ads131_spi_responder_if.sv
// SPI pin bundle between SPI_Master and the ADS131 responder.
// Master drives select and data; responder drives miso and drdy_n.
interface ads131_spi_responder_if;

  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic drdy_n;

  modport master (
    output cs_n,
    output mosi,
    input  miso,
    input  miso_oe,
    input  drdy_n
  );

  modport slave (
    input  cs_n,
    input  mosi,
    output miso,
    output miso_oe,
    output drdy_n
  );

endinterface

// File: rtl/ads131_spi_responder_shifter.sv
// Fixed-length SPI frame shifter: parallel load while idle,
// MSB-first tx/rx, bit counter, frame-complete pulse and abort.
module ads131_spi_responder_shifter #(
  parameter int FRAME_BITS = 120
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  abort,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic [FRAME_BITS-1:0] load,
  output logic                  miso,
  output logic [15:0]           rx_cmd,
  output logic                  done
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] rx;
  logic [CNT_W-1:0]      bit_cnt;

  assign miso   = tx[FRAME_BITS-1];
  assign rx_cmd = rx[FRAME_BITS-1 -: 16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else if (abort || cs_n) begin
      tx      <= load;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      rx <= {rx[FRAME_BITS-2:0], mosi};
      if (bit_cnt == LAST) begin
        // back-to-back frames start from a fresh image
        bit_cnt <= '0;
        done    <= 1'b1;
        tx      <= load;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        done    <= 1'b0;
        tx      <= {tx[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ads131_spi_responder.sv
// ADS131A0x SPI-side responder: power-up FSM, command decode,
// conversion timer and sample pattern behind a frame shifter.
module ads131_spi_responder
  import ads131_spi_responder_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int POR_CYCLES   = 1024,
  parameter int DRDY_PERIOD  = 4167
) (
  input  logic                 synthesized_clock_4_167Mhz,
  input  logic                 reset_n,
  input  logic                 hw_reset_n,
  ads131_spi_responder_if.slave spi,
  output logic                 frame_done,
  output logic [15:0]          last_cmd,
  output logic                 overflow,
  output state_t               state
);

  localparam int FRAME_BITS = (1 + NUM_CHANNELS) * WORD_BITS;
  localparam int POR_W = $clog2(POR_CYCLES);
  localparam int PER_W = $clog2(DRDY_PERIOD);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(DRDY_PERIOD - 1);

  logic                  clk;
  logic                  drdy_q;
  logic                  standby;
  logic [15:0]           next_status;
  logic [WORD_BITS-1:0]  sample_cnt;
  logic [POR_W-1:0]      por_cnt;
  logic [PER_W-1:0]      period_cnt;
  logic [FRAME_BITS-1:0] load;
  logic [15:0]           rx_cmd;
  logic                  wrap;

  assign clk         = synthesized_clock_4_167Mhz;
  assign spi.drdy_n  = drdy_q;
  assign spi.miso_oe = ~spi.cs_n & reset_n;
  assign wrap        = (period_cnt == PER_LAST);

  always_comb begin
    load = '0;
    if (state == ST_ACTIVE) begin
      load[FRAME_BITS-1 -: WORD_BITS] =
        {next_status, {(WORD_BITS-16){1'b0}}};
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        load[(NUM_CHANNELS-1-c)*WORD_BITS +: WORD_BITS] =
          sample_cnt + WORD_BITS'(c);
      end
    end
  end

  ads131_spi_responder_shifter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .abort  (~hw_reset_n),
    .cs_n   (spi.cs_n),
    .mosi   (spi.mosi),
    .load   (load),
    .miso   (spi.miso),
    .rx_cmd (rx_cmd),
    .done   (frame_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_HOLD;
      drdy_q      <= 1'b1;
      last_cmd    <= '0;
      overflow    <= 1'b0;
      standby     <= 1'b0;
      next_status <= '0;
      sample_cnt  <= '0;
      por_cnt     <= '0;
      period_cnt  <= '0;
    end else if (!hw_reset_n) begin
      state       <= ST_HOLD;
      drdy_q      <= 1'b1;
      standby     <= 1'b0;
      next_status <= '0;
      sample_cnt  <= '0;
      por_cnt     <= '0;
      period_cnt  <= '0;
    end else begin
      if (frame_done) overflow <= 1'b0;
      unique case (state)
        ST_HOLD: begin
          state   <= ST_POR;
          por_cnt <= '0;
        end
        ST_POR: begin
          if (por_cnt == POR_LAST) begin
            state       <= ST_ACTIVE;
            next_status <= STATUS_READY;
            period_cnt  <= '0;
            standby     <= 1'b0;
          end else begin
            por_cnt <= por_cnt + POR_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (frame_done) drdy_q <= 1'b1;
          // a conversion landing on frame completion keeps drdy_n low
          if (!standby) begin
            if (wrap) begin
              period_cnt <= '0;
              sample_cnt <= sample_cnt + WORD_BITS'(1);
              drdy_q     <= 1'b0;
              if (!drdy_q && !frame_done) overflow <= 1'b1;
            end else begin
              period_cnt <= period_cnt + PER_W'(1);
            end
          end
          if (frame_done) begin
            last_cmd    <= rx_cmd;
            next_status <= status_for(rx_cmd);
            unique case (1'b1)
              rx_cmd == CMD_RESET: begin
                state   <= ST_POR;
                por_cnt <= '0;
                drdy_q  <= 1'b1;
                standby <= 1'b0;
              end
              rx_cmd == CMD_STANDBY: standby <= 1'b1;
              rx_cmd == CMD_WAKEUP:  standby <= 1'b0;
              default: ;
            endcase
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
